mutex_client: RTL

//  Requester-side agent for an issue-ID-arbitrated mutex lock guarding an exclusive unit (divider, ALU).

---
 rtl/mutex_client.sv | 102 ++++++++++
 1 files changed

// File: rtl/mutex_client.sv
// Requester-side agent for an issue-ID-arbitrated mutex lock: accepts one op, acquires the
// lock, runs the shared unit once, releases the lock and hands back the result.
module mutex_client #(
   parameter int ID_WIDTH   = 4,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  op_valid,
   output logic                  op_ready,
   input  logic [ID_WIDTH-1:0]   op_issue_id,
   input  logic [DATA_WIDTH-1:0] op_data,
   input  logic                  flush,
   output logic                  lock_req,
   output logic [ID_WIDTH-1:0]   lock_issue_id,
   input  logic                  lock_grant,
   output logic                  lock_release,
   output logic                  unit_start,
   output logic [DATA_WIDTH-1:0] unit_operand,
   input  logic                  unit_done,
   input  logic [DATA_WIDTH-1:0] unit_result,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [ID_WIDTH-1:0]   res_issue_id,
   output logic [DATA_WIDTH-1:0] res_data,
   output logic [CNT_WIDTH-1:0]  stall_cnt
);

   typedef enum logic [2:0] {IDLE, REQ, START, BUSY, RESP} state_t;

   state_t                state, state_d;
   logic                  killed, killed_d;
   logic [ID_WIDTH-1:0]   id_q;
   logic [DATA_WIDTH-1:0] data_q;

   // NOTE: every variable gets a default before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d  = state;
      killed_d = killed;
      case (state)
         IDLE:  if (op_valid && !flush) state_d = REQ;
         REQ:   if (flush) state_d = IDLE;
                else if (lock_grant) state_d = START;
         START: begin
            state_d = BUSY;
            if (flush) killed_d = 1'b1;
         end
         BUSY:  if (unit_done) begin
                   killed_d = 1'b0;
                   state_d  = (killed || flush) ? IDLE : RESP;
                end else if (flush) begin
                   killed_d = 1'b1;
                end
         RESP:  if (flush || res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Release must land in the same cycle as the undone flash grant or the unit's done pulse,
   // so it is decoded from live inputs; both cases imply ownership.
   assign lock_release = (state == REQ  && lock_grant && flush) ||
                         (state == BUSY && unit_done);

   assign lock_issue_id = id_q;
   assign unit_operand  = data_q;
   assign res_issue_id  = id_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         killed     <= 1'b0;
         op_ready   <= 1'b1;
         lock_req   <= 1'b0;
         unit_start <= 1'b0;
         res_valid  <= 1'b0;
         id_q       <= '0;
         data_q     <= '0;
         res_data   <= '0;
         stall_cnt  <= '0;
      end else begin
         state      <= state_d;
         killed     <= killed_d;
         op_ready   <= (state_d == IDLE);
         lock_req   <= (state_d == REQ);
         unit_start <= (state_d == START);
         res_valid  <= (state_d == RESP);
         if (state == IDLE && op_valid && !flush) begin
            id_q   <= op_issue_id;
            data_q <= op_data;
         end
         if (state == BUSY && unit_done && !killed && !flush)
            res_data <= unit_result;
         if (state == REQ && !flush && !lock_grant && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
   end

endmodule
